// File: rtl/dac_pwm_mod.sv
// dac_pwm_mod: PWM DAC and first-order sigma-delta DAC driven from one
// reference-scaled code. The code is only reloaded at a PWM period boundary,
// so a period always completes with the code it started with.
module dac_pwm_mod #(
  parameter int DATA_W = 8,
  parameter int VREF_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic [VREF_W-1:0] vref_in,
  input  logic              vref_vld,
  output logic              pwm_out,
  output logic              sd_out,
  output logic              frame_strb,
  output logic              running,
  output logic [DATA_W-1:0] code_q
);

  localparam int PROD_W = DATA_W + VREF_W + 1;
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] acc;
  logic [VREF_W:0]   vref_plus;
  logic [PROD_W-1:0] product;
  logic [DATA_W-1:0] scaled;
  logic [DATA_W:0]   acc_sum;
  logic              both_vld;
  logic              wrap;

  // Reference scaling: full-width product, divide by 2^VREF_W afterwards.
  // (vref_in+1) never exceeds 2^VREF_W, so the quotient fits in DATA_W bits.
  always_comb begin
    vref_plus = {1'b0, vref_in} + (VREF_W+1)'(1);
    product   = PROD_W'(data_in) * PROD_W'(vref_plus);
    scaled    = DATA_W'(product >> VREF_W);
    acc_sum   = {1'b0, acc} + {1'b0, code_q};
    both_vld  = data_vld & vref_vld;
    wrap      = (cnt == CNT_MAX);
  end

  // Next-state logic: ena low always wins, start needs both loaders done.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (ena && both_vld) next_state = RUN;
      RUN:  if (!ena)            next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // State, counter, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      code_q     <= '0;
      pwm_out    <= 1'b0;
      sd_out     <= 1'b0;
      frame_strb <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      if (!ena) begin
        cnt        <= '0;
        acc        <= '0;
        pwm_out    <= 1'b0;
        sd_out     <= 1'b0;
        frame_strb <= 1'b0;
      end else if (state == IDLE) begin
        pwm_out    <= 1'b0;
        sd_out     <= 1'b0;
        frame_strb <= 1'b0;
        if (both_vld) begin
          code_q <= scaled;
          cnt    <= '0;
          acc    <= '0;
        end
      end else begin
        cnt        <= cnt + DATA_W'(1);
        pwm_out    <= (cnt < code_q);
        acc        <= acc_sum[DATA_W-1:0];
        sd_out     <= acc_sum[DATA_W];
        frame_strb <= wrap;
        if (wrap && both_vld) code_q <= scaled;
      end
    end
  end

endmodule

// File: tb/tb_dac_pwm_mod.sv
// tb_dac_pwm_mod: directed self-checking bench for dac_pwm_mod (8-bit code,
// 4-bit vref). Outputs are sampled 1 ns after each rising edge.
module tb_dac_pwm_mod;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       data_vld;
  logic [3:0] vref_in;
  logic       vref_vld;
  logic       pwm_out;
  logic       sd_out;
  logic       frame_strb;
  logic       running;
  logic [7:0] code_q;

  int checks = 0;
  int errors = 0;

  int pwm_ones;
  int sd_ones;
  int frame_ones;
  int frame_last;
  logic pwm_hist [256];
  logic sd_hist  [256];

  int shape_err;
  int alt_err;

  dac_pwm_mod #(.DATA_W(8), .VREF_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_vld   (data_vld),
    .vref_in    (vref_in),
    .vref_vld   (vref_vld),
    .pwm_out    (pwm_out),
    .sd_out     (sd_out),
    .frame_strb (frame_strb),
    .running    (running),
    .code_q     (code_q)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive all loader-side inputs at once.
  task automatic applyStimulus(input logic e, input logic [7:0] d, input logic dv,
                               input logic [3:0] v, input logic vv);
    ena      = e;
    data_in  = d;
    data_vld = dv;
    vref_in  = v;
    vref_vld = vv;
  endtask

  // One comparison: count it, and on a difference count and report it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, ending 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Run one 256-edge window, recording what the outputs did.
  task automatic measurePeriod();
    pwm_ones   = 0;
    sd_ones    = 0;
    frame_ones = 0;
    frame_last = -1;
    for (int i = 0; i < 256; i++) begin
      tick(1);
      pwm_hist[i] = pwm_out;
      sd_hist[i]  = sd_out;
      if (pwm_out)    pwm_ones++;
      if (sd_out)     sd_ones++;
      if (frame_strb) begin
        frame_ones++;
        frame_last = i;
      end
    end
  endtask

  task automatic checkAllIdle(input string tag);
    checkOutput({tag, "_running"}, {31'd0, running},    32'd0);
    checkOutput({tag, "_pwm"},     {31'd0, pwm_out},    32'd0);
    checkOutput({tag, "_sd"},      {31'd0, sd_out},     32'd0);
    checkOutput({tag, "_frame"},   {31'd0, frame_strb}, 32'd0);
  endtask

  initial begin
    // ---- reset held across an edge, then released between edges ----
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h80, 1'b1, 4'hF, 1'b1);
    #12;
    checkAllIdle("reset");
    checkOutput("reset_code_q", {24'd0, code_q}, 32'd0);
    rst_n = 1'b1;

    // ---- code 0x80, vref full scale ----
    tick(1);
    checkOutput("start_running", {31'd0, running}, 32'd1);
    checkOutput("start_code_q",  {24'd0, code_q},  32'h80);
    checkOutput("start_pwm",     {31'd0, pwm_out}, 32'd0);

    measurePeriod();
    shape_err = 0;
    alt_err   = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_hist[i] !== (i < 128)) shape_err++;
      if (sd_hist[i] !== logic'(i % 2)) alt_err++;
    end
    checkOutput("p80_pwm_ones",   pwm_ones,   32'd128);
    checkOutput("p80_pwm_shape",  shape_err,  32'd0);
    checkOutput("p80_sd_toggle",  alt_err,    32'd0);
    checkOutput("p80_frame_ones", frame_ones, 32'd1);
    checkOutput("p80_frame_pos",  frame_last, 32'd255);

    // ---- new code 0xFF*8/16 = 0x7F loaded mid-period, takes effect next ----
    applyStimulus(1'b1, 8'hFF, 1'b1, 4'h7, 1'b1);
    measurePeriod();
    checkOutput("p80b_pwm_ones",   pwm_ones,   32'd128);
    checkOutput("p80b_frame_pos",  frame_last, 32'd255);
    checkOutput("p80b_frame_ones", frame_ones, 32'd1);
    checkOutput("p7f_code_q",      {24'd0, code_q}, 32'h7F);
    measurePeriod();
    checkOutput("p7f_pwm_ones", pwm_ones, 32'd127);
    checkOutput("p7f_sd_ones",  sd_ones,  32'd127);

    // ---- code 0x40, then data changes to 0xC0 at cnt=100 ----
    applyStimulus(1'b1, 8'h40, 1'b1, 4'hF, 1'b1);
    measurePeriod();
    checkOutput("p40_code_q", {24'd0, code_q}, 32'h40);
    pwm_ones = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (pwm_out) pwm_ones++;
    end
    applyStimulus(1'b1, 8'hC0, 1'b1, 4'hF, 1'b1);
    tick(1);
    checkOutput("p40_code_hold_mid", {24'd0, code_q}, 32'h40);
    if (pwm_out) pwm_ones++;
    frame_ones = 0;
    for (int i = 101; i < 256; i++) begin
      tick(1);
      if (pwm_out)    pwm_ones++;
      if (frame_strb) frame_ones++;
    end
    checkOutput("p40_pwm_ones",   pwm_ones,   32'd64);
    checkOutput("p40_frame_ones", frame_ones, 32'd1);
    checkOutput("pc0_code_q",     {24'd0, code_q}, 32'hC0);
    measurePeriod();
    checkOutput("pc0_pwm_ones", pwm_ones, 32'd192);

    // ---- ena dropped at cnt=50 ----
    tick(50);
    applyStimulus(1'b0, 8'hC0, 1'b1, 4'hF, 1'b1);
    tick(1);
    checkAllIdle("ena_low");
    checkOutput("ena_low_code_q", {24'd0, code_q}, 32'hC0);
    tick(3);
    checkAllIdle("ena_low_hold");
    applyStimulus(1'b1, 8'h20, 1'b1, 4'hF, 1'b1);
    tick(1);
    checkOutput("restart_running", {31'd0, running}, 32'd1);
    checkOutput("restart_code_q",  {24'd0, code_q},  32'h20);
    measurePeriod();
    checkOutput("p20_pwm_first",  {31'd0, pwm_hist[0]}, 32'd1);
    checkOutput("p20_pwm_ones",   pwm_ones,   32'd32);
    checkOutput("p20_frame_pos",  frame_last, 32'd255);

    // ---- asynchronous reset between edges mid-period ----
    tick(10);
    checkOutput("pre_rst_pwm", {31'd0, pwm_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllIdle("async_rst");
    checkOutput("async_rst_code_q", {24'd0, code_q}, 32'd0);

    // ---- data_vld low blocks start ----
    applyStimulus(1'b1, 8'h10, 1'b0, 4'hF, 1'b1);
    #3;
    rst_n = 1'b1;
    tick(5);
    checkAllIdle("novld");
    checkOutput("novld_code_q", {24'd0, code_q}, 32'd0);
    applyStimulus(1'b1, 8'h10, 1'b1, 4'hF, 1'b1);
    tick(1);
    checkOutput("vld_start_running", {31'd0, running}, 32'd1);
    checkOutput("vld_start_code_q",  {24'd0, code_q},  32'h10);

    // ---- data_vld dropped in RUN: keeps running with old code ----
    applyStimulus(1'b1, 8'h90, 1'b0, 4'hF, 1'b1);
    measurePeriod();
    checkOutput("vld_drop_pwm_ones", pwm_ones, 32'd16);
    checkOutput("vld_drop_running",  {31'd0, running}, 32'd1);
    checkOutput("vld_drop_code_q",   {24'd0, code_q},  32'h10);

    // ---- boundary codes 0 and 255 ----
    applyStimulus(1'b1, 8'h00, 1'b1, 4'hF, 1'b1);
    measurePeriod();
    checkOutput("p00_code_q", {24'd0, code_q}, 32'h00);
    measurePeriod();
    checkOutput("p00_pwm_ones", pwm_ones, 32'd0);
    checkOutput("p00_sd_ones",  sd_ones,  32'd0);
    checkOutput("p00_frame_pos", frame_last, 32'd255);
    applyStimulus(1'b1, 8'hFF, 1'b1, 4'hF, 1'b1);
    measurePeriod();
    checkOutput("pff_code_q", {24'd0, code_q}, 32'hFF);
    measurePeriod();
    checkOutput("pff_pwm_ones", pwm_ones, 32'd255);
    checkOutput("pff_sd_ones",  sd_ones,  32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_pwm_mod.md
DAC_PWM_MOD -- requirements
Module: dac_pwm_mod

Interface
REQ-001 Parameter DATA_W, default 8, code width, PWM counter width and sigma-delta accumulator width.
REQ-002 Parameter VREF_W, default 4, reference-scale width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  block enable; low forces IDLE.
REQ-006 data_in  input  DATA_W  parallel code from the serial data loader.
REQ-007 data_vld  input  1  data loader stop flag; high means data_in is complete and stable.
REQ-008 vref_in  input  VREF_W  parallel reference scale from the serial vref loader.
REQ-009 vref_vld  input  1  vref loader stop flag; high means vref_in is complete and stable.
REQ-010 pwm_out  output  1  registered PWM DAC output.
REQ-011 sd_out  output  1  registered first-order sigma-delta DAC output.
REQ-012 frame_strb  output  1  one-cycle pulse at each PWM period boundary.
REQ-013 running  output  1  high while in RUN.
REQ-014 code_q  output  DATA_W  scaled code currently being modulated.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and RUN.
REQ-016 scaled SHALL be computed combinationally as (data_in * (vref_in+1)) >> VREF_W, using a product of width DATA_W+VREF_W+1 with no truncation before the shift.
REQ-017 The result of REQ-016 SHALL always fit in DATA_W bits; vref_in = all-ones SHALL give scaled = data_in.
REQ-018 IDLE->RUN SHALL occur when ena=1, data_vld=1 and vref_vld=1 are all sampled high at the same edge.
REQ-019 On the IDLE->RUN edge: code_q <= scaled, cnt <= 0, acc <= 0.
REQ-020 In RUN, on every edge: cnt <= cnt+1 (mod 2^DATA_W).
REQ-021 In RUN, on every edge: pwm_out <= (cnt < code_q), evaluated on pre-edge values.
REQ-022 In RUN, on every edge: {carry,acc} <= acc + code_q, and sd_out <= carry.
REQ-023 The PWM period SHALL be 2^DATA_W cycles with a high time of exactly code_q cycles: code 0 gives a constant low, code 255 gives 255/256 duty.
REQ-024 frame_strb SHALL be registered high for exactly the one cycle that follows an edge at which cnt == 2^DATA_W-1 in RUN.
REQ-025 At the cnt-wrap edge, code_q <= scaled if data_vld&vref_vld; otherwise code_q SHALL hold its value.
REQ-026 code_q SHALL never change mid-period.
REQ-027 Input changes occurring mid-period SHALL take effect only at the next wrap.
REQ-028 If ena is sampled low in any state: next state IDLE, and cnt, acc, pwm_out, sd_out, frame_strb all cleared at that edge.
REQ-029 On entry to IDLE via ena low, code_q SHALL hold its value.
REQ-030 In IDLE, pwm_out, sd_out and frame_strb SHALL be 0.
REQ-031 running SHALL be a registered state decode: 1 exactly when state = RUN.
REQ-032 Loss of a vld flag during RUN SHALL NOT stop modulation; it only blocks the code reload per REQ-025.

Reset
REQ-033 While rst_n=0, independent of clk: state=IDLE, and cnt, acc, code_q, pwm_out, sd_out, frame_strb, running all 0.
REQ-034 After rst_n deasserts, the first transition SHALL obey REQ-018.
REQ-035 Reset asserted mid-period SHALL abort the period immediately, with no completion of the current frame.

Verification
REQ-036 Reset release with ena=1, data_vld=1, data_in=0x80, vref_vld=1, vref_in=0xF -> running=1 after the 1st edge; pwm_out high for 128 consecutive cycles then low for 128; sd_out toggles 0,1,0,1 from the 2nd RUN edge onward; frame_strb pulses every 256 cycles.
REQ-037 data_in=0xFF, vref_in=0x7 -> code_q=0x7F; pwm_out high for 127 of every 256 cycles; sd_out has exactly 127 ones per 256 cycles.
REQ-038 Code 0x40 running; change data_in to 0xC0 at cnt=100 -> pwm_out keeps 64 high cycles for the current period; the next period after frame_strb has 192 high cycles.
REQ-039 data_vld held 0 with vref_vld=1 and ena=1 -> remains IDLE, all outputs 0. Then raise data_vld -> RUN on the next edge. Then drop data_vld in RUN -> modulation continues with the old code_q.
REQ-040 ena deasserted at cnt=50 in RUN -> at the next edge running=0 and pwm_out=sd_out=0; code_q retained. Reassert ena with both vld high -> restart with cnt=0.
REQ-041 rst_n pulsed low between edges mid-period -> all outputs 0 immediately, without waiting for a clock edge.
